// File: rtl/wb_trace_buffer.sv
// Writeback trace capture: timestamps every architectural register write into a
// FIFO drained by a valid/ready reader, and keeps cycle/stall/drop counters.
module wb_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int TS_W  = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       wb_valid,
  input  logic [4:0]                 wb_rd,
  input  logic [XLEN-1:0]            wb_data,
  input  logic [PC_W-1:0]            wb_pc,
  input  logic                       stall,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [4:0]                 out_rd,
  output logic [XLEN-1:0]            out_data,
  output logic [TS_W-1:0]            out_ts,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [TS_W-1:0]            drop_count,
  output logic [TS_W-1:0]            cycle_count,
  output logic [TS_W-1:0]            stall_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} state_t;

  function automatic logic [TS_W-1:0] sat_inc(input logic [TS_W-1:0] v);
    return (&v) ? v : v + TS_W'(1);
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic               ovf_q, ovf_d;
  logic [TS_W-1:0]    drop_q, drop_d;
  logic [TS_W-1:0]    cyc_q, cyc_d;
  logic [TS_W-1:0]    stall_q, stall_d;

  logic [PC_W-1:0]    pc_mem   [DEPTH];
  logic [4:0]         rd_mem   [DEPTH];
  logic [XLEN-1:0]    data_mem [DEPTH];
  logic [TS_W-1:0]    ts_mem   [DEPTH];

  logic push, pop, push_acc, pop_acc;

  // x0 writes and stalled writebacks are not architectural writes
  assign push      = wb_valid && (wb_rd != 5'd0) && !stall;
  assign out_valid = (state_q != S_EMPTY);
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    cyc_d    = cyc_q + TS_W'(1);
    stall_d  = stall ? sat_inc(stall_q) : stall_q;
    push_acc = 1'b0;
    pop_acc  = 1'b0;

    case (state_q)
      S_EMPTY: begin
        if (push) begin
          push_acc = 1'b1;
          count_d  = CNT_W'(1);
          state_d  = S_PARTIAL;
        end
      end
      S_PARTIAL: begin
        push_acc = push;
        pop_acc  = pop;
        if (push && !pop) begin
          count_d = count_q + CNT_W'(1);
          if (count_q == FULL_CNT - CNT_W'(1)) state_d = S_FULL;
        end else if (pop && !push) begin
          count_d = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        // A push only fits when the head leaves in the same cycle
        pop_acc  = pop;
        push_acc = push && pop;
        if (push && !pop) begin
          ovf_d  = 1'b1;
          drop_d = sat_inc(drop_q);
        end else if (pop && !push) begin
          count_d = count_q - CNT_W'(1);
          state_d = S_PARTIAL;
        end
      end
      default: state_d = S_EMPTY;
    endcase

    if (push_acc) wr_d = wr_q + PTR_W'(1);
    if (pop_acc)  rd_d = rd_q + PTR_W'(1);

    if (clear) begin
      state_d  = S_EMPTY;
      count_d  = '0;
      wr_d     = '0;
      rd_d     = '0;
      ovf_d    = 1'b0;
      drop_d   = '0;
      cyc_d    = '0;
      stall_d  = '0;
      push_acc = 1'b0;
      pop_acc  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_EMPTY;
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
      cyc_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
      cyc_q   <= cyc_d;
      stall_q <= stall_d;
    end
  end

  // Entry storage carries no reset; outputs are masked by out_valid instead
  always_ff @(posedge clock) begin
    if (push_acc) begin
      pc_mem[wr_q]   <= wb_pc;
      rd_mem[wr_q]   <= wb_rd;
      data_mem[wr_q] <= wb_data;
      ts_mem[wr_q]   <= cyc_q;
    end
  end

  assign out_pc      = out_valid ? pc_mem[rd_q]   : '0;
  assign out_rd      = out_valid ? rd_mem[rd_q]   : '0;
  assign out_data    = out_valid ? data_mem[rd_q] : '0;
  assign out_ts      = out_valid ? ts_mem[rd_q]   : '0;
  assign count       = count_q;
  assign overflow    = ovf_q;
  assign drop_count  = drop_q;
  assign cycle_count = cyc_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer: directed table, corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_wb_trace_buffer;

  localparam int DEPTH = 16;
  localparam int TS    = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic [31:0] wb_pc = '0;
  logic        stall = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [4:0]  out_rd;
  logic [31:0] out_data;
  logic [TS-1:0] out_ts;
  logic [4:0]  count;
  logic        overflow;
  logic [TS-1:0] drop_count, cycle_count, stall_count;

  wb_trace_buffer #(.DEPTH(DEPTH), .XLEN(32), .PC_W(32), .TS_W(TS)) dut (
    .clock(clock), .reset(reset), .clear(clear), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_pc(wb_pc), .stall(stall),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rd(out_rd), .out_data(out_data), .out_ts(out_ts), .count(count),
    .overflow(overflow), .drop_count(drop_count), .cycle_count(cycle_count),
    .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0]   pc;
    logic [4:0]    rd;
    logic [31:0]   data;
    logic [TS-1:0] ts;
  } ent_t;

  ent_t          mq[$];
  logic [TS-1:0] m_cyc, m_stall, m_drop;
  logic          m_ovf;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_cyc = '0; m_stall = '0; m_drop = '0; m_ovf = 1'b0;
  endtask

  // Applies the current inputs to the model for one clock edge
  task automatic model_step();
    bit full, pop, push;
    ent_t e;
    if (clear) begin
      model_reset();
    end else begin
      full = (mq.size() == DEPTH);
      pop  = (mq.size() != 0) && out_ready;
      push = wb_valid && (wb_rd != 0) && !stall;
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (full && !pop) begin
          m_ovf = 1'b1;
          if (m_drop != {TS{1'b1}}) m_drop = m_drop + 1'b1;
        end else begin
          e.pc = wb_pc; e.rd = wb_rd; e.data = wb_data; e.ts = m_cyc;
          mq.push_back(e);
        end
      end
      if (stall && m_stall != {TS{1'b1}}) m_stall = m_stall + 1'b1;
      m_cyc = m_cyc + 1'b1;
    end
  endtask

  task automatic compare_all();
    ent_t h;
    h = '{pc: '0, rd: '0, data: '0, ts: '0};
    if (mq.size() != 0) h = mq[0];
    check("out_valid", out_valid, mq.size() != 0);
    check("count", count, mq.size());
    check("out_pc", out_pc, h.pc);
    check("out_rd", out_rd, h.rd);
    check("out_data", out_data, h.data);
    check("out_ts", out_ts, h.ts);
    check("overflow", overflow, m_ovf);
    check("drop_count", drop_count, m_drop);
    check("cycle_count", cycle_count, m_cyc);
    check("stall_count", stall_count, m_stall);
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic set_in(input logic v, input logic [4:0] rd, input logic [31:0] d,
                        input logic [31:0] pc, input logic st, input logic rdy);
    wb_valid = v; wb_rd = rd; wb_data = d; wb_pc = pc; stall = st; out_ready = rdy;
  endtask

  typedef struct {
    logic v; logic [4:0] rd; logic [31:0] d; logic [31:0] pc; logic st; logic rdy;
    logic [4:0] e_cnt; logic e_vld; logic [31:0] e_pc; logic [4:0] e_rd;
    logic [31:0] e_data; logic [TS-1:0] e_ts; logic [TS-1:0] e_stall;
    logic [TS-1:0] e_cyc; logic [TS-1:0] e_drop;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL watchdog expired=1 required=0");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{1'b0, 5'd0, 32'd0,  32'd0,  1'b0, 1'b1, 5'd0, 1'b0, 32'd0, 5'd0, 32'd0,  8'd0, 8'd0, 8'd1,  8'd0};
    tbl[1] = '{1'b0, 5'd0, 32'd0,  32'd0,  1'b0, 1'b1, 5'd0, 1'b0, 32'd0, 5'd0, 32'd0,  8'd0, 8'd0, 8'd2,  8'd0};
    tbl[2] = '{1'b1, 5'd5, 32'd10, 32'd0,  1'b0, 1'b1, 5'd1, 1'b1, 32'd0, 5'd5, 32'd10, 8'd2, 8'd0, 8'd3,  8'd0};
    tbl[3] = '{1'b1, 5'd6, 32'd20, 32'd4,  1'b0, 1'b1, 5'd1, 1'b1, 32'd4, 5'd6, 32'd20, 8'd3, 8'd0, 8'd4,  8'd0};
    tbl[4] = '{1'b0, 5'd0, 32'd0,  32'd0,  1'b0, 1'b1, 5'd0, 1'b0, 32'd0, 5'd0, 32'd0,  8'd0, 8'd0, 8'd5,  8'd0};
    tbl[5] = '{1'b1, 5'd0, 32'd99, 32'd8,  1'b0, 1'b1, 5'd0, 1'b0, 32'd0, 5'd0, 32'd0,  8'd0, 8'd0, 8'd6,  8'd0};
    tbl[6] = '{1'b1, 5'd7, 32'd33, 32'd12, 1'b1, 1'b1, 5'd0, 1'b0, 32'd0, 5'd0, 32'd0,  8'd0, 8'd1, 8'd7,  8'd0};
    tbl[7] = '{1'b1, 5'd7, 32'd33, 32'd12, 1'b1, 1'b1, 5'd0, 1'b0, 32'd0, 5'd0, 32'd0,  8'd0, 8'd2, 8'd8,  8'd0};
    tbl[8] = '{1'b1, 5'd7, 32'd33, 32'd12, 1'b1, 1'b1, 5'd0, 1'b0, 32'd0, 5'd0, 32'd0,  8'd0, 8'd3, 8'd9,  8'd0};
    tbl[9] = '{1'b0, 5'd0, 32'd0,  32'd0,  1'b0, 1'b1, 5'd0, 1'b0, 32'd0, 5'd0, 32'd0,  8'd0, 8'd3, 8'd10, 8'd0};

    model_reset();
    repeat (3) @(posedge clock);
    #2;
    check("rst_valid", out_valid, 1'b0);
    check("rst_count", count, 0);
    check("rst_data", out_data, 0);
    check("rst_cycle", cycle_count, 0);
    reset = 1'b1;

    // Directed writeback sequence and filtered writes
    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].v, tbl[i].rd, tbl[i].d, tbl[i].pc, tbl[i].st, tbl[i].rdy);
      tick();
      check($sformatf("tbl%0d_count", i), count, tbl[i].e_cnt);
      check($sformatf("tbl%0d_valid", i), out_valid, tbl[i].e_vld);
      check($sformatf("tbl%0d_pc", i), out_pc, tbl[i].e_pc);
      check($sformatf("tbl%0d_rd", i), out_rd, tbl[i].e_rd);
      check($sformatf("tbl%0d_data", i), out_data, tbl[i].e_data);
      check($sformatf("tbl%0d_ts", i), out_ts, tbl[i].e_ts);
      check($sformatf("tbl%0d_stall", i), stall_count, tbl[i].e_stall);
      check($sformatf("tbl%0d_cyc", i), cycle_count, tbl[i].e_cyc);
      check($sformatf("tbl%0d_drop", i), drop_count, tbl[i].e_drop);
    end

    // Overflow: 18 writes into a 16-deep FIFO with the reader stalled
    for (int i = 0; i < 18; i++) begin
      set_in(1'b1, 5'd1, 32'd100 + i, 32'h100 + 4 * i, 1'b0, 1'b0);
      tick();
    end
    set_in(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    check("ovf_count", count, 16);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_drops", drop_count, 2);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain%0d_data", i), out_data, 32'd100 + i);
      out_ready = 1'b1;
      tick();
    end
    check("drain_empty", out_valid, 1'b0);

    // Clear coincident with a push while entries are buffered and overflow is set
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 5'd2, 32'd300 + i, 32'd0, 1'b0, 1'b0);
      tick();
    end
    clear = 1'b1;
    set_in(1'b1, 5'd3, 32'd999, 32'd0, 1'b0, 1'b0);
    tick();
    clear = 1'b0;
    check("clr_count", count, 0);
    check("clr_valid", out_valid, 1'b0);
    check("clr_cycle", cycle_count, 0);
    check("clr_ovf", overflow, 1'b0);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 16; i++) begin
      set_in(1'b1, 5'd4, 32'd200 + i, 32'd0, 1'b0, 1'b0);
      tick();
    end
    set_in(1'b1, 5'd4, 32'hABCD, 32'd0, 1'b0, 1'b1);
    tick();
    check("pp_count", count, 16);
    check("pp_ovf", overflow, 1'b0);
    set_in(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("pp_drain%0d", i), out_data, (i == 15) ? 32'hABCD : 32'd201 + i);
      tick();
    end

    // Asynchronous reset mid-drain
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 5'd9, 32'd400 + i, 32'd0, 1'b0, 1'b0);
      tick();
    end
    set_in(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    #3 reset = 1'b0;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_count", count, 0);
    #2 reset = 1'b1;
    model_reset();
    check("arst_cycle", cycle_count, 0);
    tick();

    // Randomized traffic with varying reader throughput
    for (int i = 0; i < 2000; i++) begin
      int rdy_pct;
      rdy_pct = ((i / 250) % 2 == 0) ? 85 : 15;
      wb_valid  = ($urandom_range(0, 99) < 60);
      wb_rd     = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      wb_data   = $urandom;
      wb_pc     = $urandom & 32'hFFFF_FFFC;
      stall     = ($urandom_range(0, 99) < 25);
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      clear     = ($urandom_range(0, 999) == 0);
      tick();
    end
    clear = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
